// File: rtl/booth_mul_pkg.sv
// booth_mul_pkg: shared ALU constants, Booth digit and FSM state types
package booth_mul_pkg;
  localparam int WIDTH = 32;
  typedef enum logic [2:0] {ZERO, PM, P2M, NM, N2M} digit_e;
  typedef enum logic {IDLE, RUN} state_e;
  function automatic digit_e booth_decode(input logic [2:0] w);
    return (w == 3'b011) ? P2M :
           (w == 3'b100) ? N2M :
           (w == 3'b001 || w == 3'b010) ? PM :
           (w == 3'b101 || w == 3'b110) ? NM : ZERO;
  endfunction
endpackage

// File: rtl/booth_mul_if.sv
// booth_mul_if: start/done handshake, operands and product of the multiplier
interface booth_mul_if;
  import booth_mul_pkg::*;
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] zlow;
  logic [WIDTH-1:0] zhigh;
  logic             busy;
  logic             done;
  modport master (output start, in1, in2, input zlow, zhigh, busy, done);
  modport slave (input start, in1, in2, output zlow, zhigh, busy, done);
endinterface

// File: rtl/booth_r4_digit.sv
// booth_r4_digit: maps a radix-4 Booth window and multiplicand to its addend
module booth_r4_digit
  import booth_mul_pkg::*;
#(
  parameter int AW = WIDTH + 2
) (
  input  logic [2:0]    win,
  input  logic [AW-1:0] m,
  output logic [AW-1:0] addend
);
  digit_e        digit;
  logic [AW-1:0] m2;
  assign digit = booth_decode(win);
  assign m2    = m << 1;
  always_comb begin
    addend = (digit == PM)  ? m   :
             (digit == P2M) ? m2  :
             (digit == NM)  ? -m  :
             (digit == N2M) ? -m2 : '0;
  end
endmodule

// File: rtl/booth_mul.sv
// booth_mul: sequential signed radix-4 Booth multiplier, WIDTH/2 steps per product
module booth_mul
  import booth_mul_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  booth_mul_if.slave bus
);
  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH / 2);
  state_e           state, state_nx;
  logic [AW-1:0]    m, acc, addend, sum, acc_nx;
  logic [WIDTH-1:0] q, q_nx;
  logic             q_m1, last, take;
  logic [CW-1:0]    cnt;
  booth_r4_digit #(.AW(AW)) u_digit (
    .win    ({q[1:0], q_m1}),
    .m      (m),
    .addend (addend)
  );
  assign sum      = acc + addend;
  assign acc_nx   = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign q_nx     = {sum[1:0], q[WIDTH-1:2]};
  assign last     = cnt == CW'(WIDTH / 2 - 1);
  assign take     = state == IDLE && bus.start;
  assign bus.busy = state == RUN;
  always_comb begin
    state_nx = take ? RUN : (state == RUN && last) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // accumulator and multiplier shift right by 2 as one {acc, q, q_m1} register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m         <= '0;
      acc       <= '0;
      q         <= '0;
      q_m1      <= 1'b0;
      cnt       <= '0;
      bus.zlow  <= '0;
      bus.zhigh <= '0;
      bus.done  <= 1'b0;
    end else begin
      bus.done <= state == RUN && last;
      if (take) begin
        m    <= {{2{bus.in1[WIDTH-1]}}, bus.in1};
        q    <= bus.in2;
        acc  <= '0;
        q_m1 <= 1'b0;
        cnt  <= '0;
      end else if (state == RUN) begin
        acc  <= acc_nx;
        q    <= q_nx;
        q_m1 <= q[1];
        cnt  <= cnt + 1'b1;
        if (last) {bus.zhigh, bus.zlow} <= {acc_nx[WIDTH-1:0], q_nx};
      end
    end
  end
endmodule

// File: tb/tb_booth_mul.sv
// tb_booth_mul: directed vector table plus handshake, abort and back-to-back sequences
module tb_booth_mul;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  booth_mul_if bus ();
  booth_mul dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;
  vec_t vecs[10];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1 = a;
    bus.in2 = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask
  initial begin
    int lat, prev, pulses, unstable;
    vecs[0] = '{32'd16, 32'd42, 64'h0000_0000_0000_02A0};
    vecs[1] = '{32'd12, 32'd42, 64'h0000_0000_0000_01F8};
    vecs[2] = '{32'd21, 32'd42, 64'h0000_0000_0000_0372};
    vecs[3] = '{32'hFFFF_FFFF, 32'd42, 64'hFFFF_FFFF_FFFF_FFD6};
    vecs[4] = '{32'd42, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFD6};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
    vecs[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    vecs[8] = '{32'd0, 32'd5, 64'h0};
    vecs[9] = '{32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    bus.start = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    repeat (3) @(negedge clk);
    check("reset_product", {bus.zhigh, bus.zlow}, 64'h0);
    check("reset_busy_done", {62'h0, bus.busy, bus.done}, 64'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd16);
      check($sformatf("vec%0d_product", i), {bus.zhigh, bus.zlow}, vecs[i].p);
      check($sformatf("vec%0d_busy_at_done", i), {63'h0, bus.busy}, 64'h0);
      @(negedge clk);
      check($sformatf("vec%0d_done_one_cycle", i), {63'h0, bus.done}, 64'h0);
    end
    // start and operand changes while busy must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1 = 32'd1000;
    bus.in2 = 32'hFFFF_FFFB;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    repeat (4) begin @(negedge clk); lat++; end
    bus.start = 1'b1;
    bus.in1 = 32'd3;
    bus.in2 = 32'd3;
    @(negedge clk);
    lat++;
    bus.start = 1'b0;
    bus.in1 = 32'd9;
    bus.in2 = 32'd9;
    check("busy_mid_run", {63'h0, bus.busy}, 64'h1);
    check("hold_previous_product", {bus.zhigh, bus.zlow}, vecs[9].p);
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ignored_start_latency", 64'(lat), 64'd16);
    check("ignored_start_product", {bus.zhigh, bus.zlow}, 64'hFFFF_FFFF_FFFF_EC78);
    @(negedge clk);
    check("no_restart_after_ignored_start", {63'h0, bus.busy}, 64'h0);
    // asynchronous abort mid-run
    bus.start = 1'b1;
    bus.in1 = 32'd5;
    bus.in2 = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_product", {bus.zhigh, bus.zlow}, 64'h0);
    check("abort_busy_done", {62'h0, bus.busy, bus.done}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    // back-to-back with start held high
    bus.start = 1'b1;
    bus.in1 = 32'd7;
    bus.in2 = 32'hFFFF_FFFD;
    prev = -1;
    pulses = 0;
    unstable = 0;
    for (int k = 0; k < 80 && pulses < 3; k++) begin
      @(negedge clk);
      if (bus.done) begin
        check($sformatf("b2b%0d_product", pulses), {bus.zhigh, bus.zlow}, 64'hFFFF_FFFF_FFFF_FFEB);
        if (prev >= 0) check($sformatf("b2b%0d_spacing", pulses), 64'(cyc - prev), 64'd17);
        prev = cyc;
        pulses++;
      end else if (pulses > 0 && {bus.zhigh, bus.zlow} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
        unstable++;
      end
    end
    bus.start = 1'b0;
    check("b2b_pulse_count", 64'(pulses), 64'd3);
    check("b2b_outputs_stable", 64'(unstable), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/booth_mul.md
Name: booth_mul

Overview:
Sequential signed two's-complement multiplier for the ALU datapath, using radix-4 (modified) Booth recoding.
- Takes two 32-bit operands, in1 (multiplicand) and in2 (multiplier).
- Produces the full 64-bit product split into zhigh (upper word) and zlow (lower word), ready for the HI/LO registers.
- Runs a start/done handshake; one product takes 16 iteration cycles.

Parameters:
WIDTH, 32, operand width in bits; must be even; product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle request; operands sampled when start=1 and busy=0
in1  input  WIDTH  multiplicand, signed
in2  input  WIDTH  multiplier, signed
zlow  output  WIDTH  product bits [WIDTH-1:0]
zhigh  output  WIDTH  product bits [2*WIDTH-1:WIDTH]
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when zhigh/zlow are updated with a new product

Behaviour:
- Reset (rst_n=0, asynchronous) clears zlow, zhigh, busy, done and all internal state to 0 and forces state IDLE.
- Reset asserted mid-operation aborts it; no done pulse is produced.
- Two states: IDLE and RUN.
- IDLE, on a rising edge with start=1:
  - latch in1 and in2;
  - clear the partial-product accumulator;
  - set iteration count to 0 and the Booth guard bit q[-1] to 0;
  - go to RUN, busy=1.
- RUN, each rising edge performs one radix-4 step on the 3-bit window {q[2i+1], q[2i], q[2i-1]}:
  - 000 and 111 -> +0
  - 001 and 010 -> +M
  - 011 -> +2M
  - 100 -> -2M
  - 101 and 110 -> -M
- M is the multiplicand sign-extended to WIDTH+2 bits. After each add, the accumulator/multiplier pair is arithmetic-shifted right by 2.
- After WIDTH/2 = 16 steps:
  - zhigh and zlow are loaded with the 64-bit signed product;
  - done=1 for exactly one cycle and busy=0;
  - state returns to IDLE.
- Latency: the result is visible 16 edges after the start-capture edge, and done is high in that same cycle.
- start while busy is ignored. in1/in2 changes after capture have no effect.
- zhigh/zlow hold the last completed product until the next completion. They never show intermediate values.
- start asserted in the same cycle as done (IDLE reached) is accepted on the next edge: back-to-back operation.
- Arithmetic is signed × signed. The most negative operands must be exact, with no overflow; the internal accumulator is WIDTH+2 bits to guarantee this.
- Zero operands still take the full 16 cycles; there is no early termination.

Decomposition:
- Shared ALU package holds:
  - the WIDTH constant (32);
  - the Booth-digit encoding enum (ZERO, PM, P2M, NM, N2M);
  - the state enum (IDLE, RUN).
- One natural sub-module: booth_r4_digit. It is combinational; it maps the 3-bit window plus M to the selected addend (0, ±M, ±2M) at WIDTH+2 bits.
- The top level holds the FSM, counter, accumulator and shifter.

Test Plan:
- in2=42 fixed, in1=16 then 12 then 21, each started after the previous done -> {zhigh,zlow} = 0x0/0x2A0, 0x0/0x1F8, 0x0/0x372. done pulses exactly 16 edges after each start edge.
- in1=-1 (0xFFFFFFFF), in2=42 -> zhigh=0xFFFFFFFF, zlow=0xFFFFFFD6. Same result with the operands swapped.
- in1=in2=0x80000000 -> zhigh=0x40000000, zlow=0x00000000. Also in1=0x80000000, in2=0x7FFFFFFF -> zhigh=0xC0000000, zlow=0x80000000.
- Mid-run checks:
  - Pulse start again and change in1/in2 while busy -> ignored; the original product is reported.
  - Then deassert rst_n mid-RUN -> all outputs 0 immediately, no done pulse.
- Back-to-back: start held high continuously with in1=7, in2=-3 -> consecutive done pulses 17 cycles apart, each with zhigh=0xFFFFFFFF, zlow=0xFFFFFFEB. Outputs stable between pulses.
